// File: rtl/mm_bram_ktiled_dpath.sv
// K-tiled signed matrix-multiply datapath: one output row of C = A*W per K_TILES beats.
// Define MM_KTILED_SAT_EN to saturate narrowed outputs instead of wrapping them.
module mm_bram_ktiled_dpath #(
  parameter int DATA_WIDTH = 8,
  parameter int ROW_NUM    = 32,
  parameter int COL_NUM    = 32,
  parameter int LENGTH     = 32,
  parameter int K_TILES    = 4,
  parameter int ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(LENGTH * K_TILES),
  parameter int OUT_SHIFT  = DATA_WIDTH,
  localparam int ROW_ADDR_WIDTH = $clog2(ROW_NUM),
  localparam int TILE_W         = (K_TILES > 1) ? $clog2(K_TILES) : 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_val,
  input  logic                                 in_first,
  input  logic                                 in_last_row,
  input  logic [ROW_ADDR_WIDTH-1:0]            in_row_addr,
  input  logic [DATA_WIDTH*LENGTH-1:0]         row_data_in,
  input  logic [DATA_WIDTH*LENGTH*COL_NUM-1:0] weights,
  output logic [DATA_WIDTH*COL_NUM-1:0]        row_data_out,
  output logic [ROW_ADDR_WIDTH*COL_NUM-1:0]    row_wraddr,
  output logic [COL_NUM-1:0]                   row_wr_en,
  output logic                                 last_val,
  output logic                                 busy,
  output logic                                 seq_err
);

  localparam int PROD_W = 2 * DATA_WIDTH;

  // ---------------------------------------------------------------------------
  // Tile sequencing
  // ---------------------------------------------------------------------------
  logic [TILE_W-1:0] tcnt;
  logic [TILE_W-1:0] tile_c;
  logic [TILE_W-1:0] tcnt_next_c;
  logic              last_tile_c;
  logic              err_c;

  // NOTE: every variable gets a default at the top of an always_comb so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    tile_c      = '0;
    err_c       = 1'b0;
    last_tile_c = 1'b1;
    if (K_TILES > 1) begin
      // A restart with in_first abandons the partial row: tile 0 reloads the accumulator.
      if (in_first) begin
        err_c = (tcnt != '0);
      end else if (tcnt == '0) begin
        err_c = 1'b1;
      end else begin
        tile_c = tcnt;
      end
      last_tile_c = (tile_c == TILE_W'(K_TILES - 1));
    end
    tcnt_next_c = last_tile_c ? '0 : tile_c + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt    <= '0;
      seq_err <= 1'b0;
    end else if (in_val) begin
      tcnt <= tcnt_next_c;
      if (err_c) seq_err <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: element-wise signed products
  // ---------------------------------------------------------------------------
  logic signed [PROD_W-1:0] prod_c  [COL_NUM][LENGTH];
  logic signed [PROD_W-1:0] s1_prod [COL_NUM][LENGTH];
  logic                     s1_valid;
  logic [TILE_W-1:0]        s1_tile;
  logic                     s1_last;
  logic [ROW_ADDR_WIDTH-1:0] s1_addr;
  logic                     s1_last_row;

  always_comb begin
    for (int j = 0; j < COL_NUM; j++) begin
      for (int i = 0; i < LENGTH; i++) begin
        prod_c[j][i] = PROD_W'($signed(row_data_in[i*DATA_WIDTH +: DATA_WIDTH]))
                     * PROD_W'($signed(weights[(i*COL_NUM+j)*DATA_WIDTH +: DATA_WIDTH]));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) s1_valid <= 1'b0;
    else       s1_valid <= in_val;
  end

  // NOTE: payload registers carry no reset; they are only consumed when the
  // matching valid bit, which is reset, says they hold a live beat.
  always_ff @(posedge clk) begin
    if (in_val) begin
      s1_prod     <= prod_c;
      s1_tile     <= tile_c;
      s1_last     <= last_tile_c;
      s1_addr     <= in_row_addr;
      s1_last_row <= in_last_row;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: per-column reduction of LENGTH products
  // ---------------------------------------------------------------------------
  logic signed [ACC_WIDTH-1:0] sum_c  [COL_NUM];
  logic signed [ACC_WIDTH-1:0] s2_sum [COL_NUM];
  logic                        s2_valid;
  logic                        s2_first;
  logic                        s2_last;
  logic [ROW_ADDR_WIDTH-1:0]   s2_addr;
  logic                        s2_last_row;

  always_comb begin
    for (int j = 0; j < COL_NUM; j++) begin
      sum_c[j] = '0;
      for (int i = 0; i < LENGTH; i++) begin
        sum_c[j] = sum_c[j] + ACC_WIDTH'(s1_prod[j][i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) s2_valid <= 1'b0;
    else       s2_valid <= s1_valid;
  end

  always_ff @(posedge clk) begin
    if (s1_valid) begin
      s2_sum      <= sum_c;
      s2_first    <= (s1_tile == '0);
      s2_last     <= s1_last;
      s2_addr     <= s1_addr;
      s2_last_row <= s1_last_row;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: cross-tile accumulation, narrowing and the write port
  // ---------------------------------------------------------------------------
`ifdef MM_KTILED_SAT_EN
  localparam int                          SAT_MAX_I = (1 << (DATA_WIDTH - 1)) - 1;
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX   = ACC_WIDTH'(SAT_MAX_I);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN   = ACC_WIDTH'(-SAT_MAX_I - 1);
`endif

  function automatic logic [DATA_WIDTH-1:0] narrow(input logic signed [ACC_WIDTH-1:0] v);
`ifdef MM_KTILED_SAT_EN
    if (v > SAT_MAX)      return SAT_MAX[DATA_WIDTH-1:0];
    else if (v < SAT_MIN) return SAT_MIN[DATA_WIDTH-1:0];
    else                  return v[DATA_WIDTH-1:0];
`else
    return DATA_WIDTH'(v);
`endif
  endfunction

  logic signed [ACC_WIDTH-1:0] acc        [COL_NUM];
  logic signed [ACC_WIDTH-1:0] acc_next_c [COL_NUM];
  logic signed [ACC_WIDTH-1:0] shifted_c  [COL_NUM];
  logic [DATA_WIDTH-1:0]       narrow_c   [COL_NUM];
  logic                        out_valid;

  always_comb begin
    for (int j = 0; j < COL_NUM; j++) begin
      acc_next_c[j] = s2_first ? s2_sum[j] : acc[j] + s2_sum[j];
      shifted_c[j]  = acc_next_c[j] >>> OUT_SHIFT;
      narrow_c[j]   = narrow(shifted_c[j]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < COL_NUM; j++) acc[j] <= '0;
      out_valid    <= 1'b0;
      row_data_out <= '0;
      row_wraddr   <= '0;
      last_val     <= 1'b0;
    end else begin
      out_valid    <= s2_valid && s2_last;
      row_data_out <= '0;
      row_wraddr   <= '0;
      last_val     <= 1'b0;
      if (s2_valid) begin
        for (int j = 0; j < COL_NUM; j++) acc[j] <= acc_next_c[j];
      end
      if (s2_valid && s2_last) begin
        for (int j = 0; j < COL_NUM; j++) row_data_out[j*DATA_WIDTH +: DATA_WIDTH] <= narrow_c[j];
        row_wraddr <= {COL_NUM{s2_addr}};
        last_val   <= s2_last_row;
      end
    end
  end

  assign row_wr_en = {COL_NUM{out_valid}};
  assign busy      = (tcnt != '0) || s1_valid || s2_valid || out_valid;

endmodule
